// File: rtl/cga_attrib_ctrl.sv
// cga_attrib_ctrl: CGA/Tandy mode, colour and gate-array registers with vsync-staged updates, cursor blink and 3DA status
//   clk, reset          : system clock, synchronous active-high reset
//   io_cs/io_a/io_wr/io_rd/io_din/io_dout : CPU port window 3D0-3DF, registered read data
//   vsync, display_enable : CRTC timing inputs
//   hres_mode..blink_enabled : active mode register bits 0..5
//   cga_color_reg       : active colour-select register
//   tandy_bordercol/tandy_16_mode/tandy_color_4 : active Tandy gate-array fields
//   blink               : cursor blink square wave
module cga_attrib_ctrl #(
   parameter bit SYNC_UPDATE  = 1'b1,
   parameter int BLINK_FRAMES = 8,
   parameter bit TANDY_EN     = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       io_cs,
   input  logic [3:0] io_a,
   input  logic       io_wr,
   input  logic       io_rd,
   input  logic [7:0] io_din,
   output logic [7:0] io_dout,
   input  logic       vsync,
   input  logic       display_enable,
   output logic       hres_mode,
   output logic       grph_mode,
   output logic       bw_mode,
   output logic       video_enable,
   output logic       mode_640,
   output logic       blink_enabled,
   output logic [7:0] cga_color_reg,
   output logic [3:0] tandy_bordercol,
   output logic       tandy_16_mode,
   output logic       tandy_color_4,
   output logic       blink
);
   localparam logic [7:0] LAST = 8'(BLINK_FRAMES - 1);
   logic       wr, rd, wr_mode, wr_color, wr_idx, wr_tdata, wr_border, wr_mode2;
   logic       vs_q, vs_prev, vs_edge, wr_q, load, blink_wrap;
   logic [5:0] mode_stage, mode_act, mode_nxt;
   logic [7:0] color_stage, color_act, color_nxt;
   logic [3:0] border_stage, border_act, border_nxt;
   logic [1:0] mode2_stage, mode2_act, mode2_nxt;
   logic [4:0] tandy_idx;
   logic [7:0] frame_cnt, rd_data;
   always_comb begin
      wr         = io_cs & io_wr;
      rd         = io_cs & io_rd & ~io_wr;
      wr_mode    = wr & (io_a == 4'h8);
      wr_color   = wr & (io_a == 4'h9);
      wr_idx     = wr & (io_a == 4'hA) & TANDY_EN;
      wr_tdata   = wr & (io_a == 4'hE) & TANDY_EN;
      wr_border  = wr_tdata & (tandy_idx == 5'd2);
      wr_mode2   = wr_tdata & (tandy_idx == 5'd3);
      // Next stage values double as the load source so a write coinciding
      // with a load is applied directly instead of the stale stage value.
      mode_nxt   = wr_mode ? io_din[5:0] : mode_stage;
      color_nxt  = wr_color ? io_din : color_stage;
      border_nxt = wr_border ? io_din[3:0] : border_stage;
      mode2_nxt  = wr_mode2 ? io_din[4:3] : mode2_stage;
      vs_edge    = vs_q & ~vs_prev;
      load       = SYNC_UPDATE ? vs_edge : wr_q;
      blink_wrap = frame_cnt == LAST;
      rd_data    = io_a == 4'hA ? {4'hF, vsync, 2'b10, ~display_enable} :
                   io_a == 4'h8 ? {2'b11, mode_stage} :
                   io_a == 4'h9 ? color_stage : 8'hFF;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         vs_q         <= 1'b0;
         vs_prev      <= 1'b0;
         wr_q         <= 1'b0;
         mode_stage   <= '0;
         color_stage  <= '0;
         border_stage <= '0;
         mode2_stage  <= '0;
         mode_act     <= '0;
         color_act    <= '0;
         border_act   <= '0;
         mode2_act    <= '0;
         tandy_idx    <= '0;
         frame_cnt    <= '0;
         blink        <= 1'b0;
         io_dout      <= 8'hFF;
      end else begin
         vs_q         <= vsync;
         vs_prev      <= vs_q;
         wr_q         <= wr;
         mode_stage   <= mode_nxt;
         color_stage  <= color_nxt;
         border_stage <= border_nxt;
         mode2_stage  <= mode2_nxt;
         if (wr_idx) tandy_idx <= io_din[4:0];
         if (load) begin
            mode_act   <= mode_nxt;
            color_act  <= color_nxt;
            border_act <= border_nxt;
            mode2_act  <= mode2_nxt;
         end
         if (vs_edge) begin
            frame_cnt <= blink_wrap ? 8'd0 : frame_cnt + 8'd1;
            if (blink_wrap) blink <= ~blink;
         end
         if (rd) io_dout <= rd_data;
      end
   end
   assign hres_mode       = mode_act[0];
   assign grph_mode       = mode_act[1];
   assign bw_mode         = mode_act[2];
   assign video_enable    = mode_act[3];
   assign mode_640        = mode_act[4];
   assign blink_enabled   = mode_act[5];
   assign cga_color_reg   = color_act;
   assign tandy_bordercol = TANDY_EN ? border_act : 4'h0;
   assign tandy_16_mode   = TANDY_EN & mode2_act[1];
   assign tandy_color_4   = TANDY_EN & mode2_act[0];
endmodule

// File: tb/tb_cga_attrib_ctrl.sv
// tb_cga_attrib_ctrl: directed self-checking bench for cga_attrib_ctrl
module tb_cga_attrib_ctrl;
   logic       clk = 0, reset = 0, io_cs = 0, io_wr = 0, io_rd = 0, vsync = 0, display_enable = 0;
   logic [3:0] io_a = 0;
   logic [7:0] io_din = 0;
   int         checks = 0, failures = 0;
   logic [7:0] dout_m, dout_a, dout_n, col_m, col_a, col_n;
   logic [5:0] mode_m, mode_a, mode_n;
   logic [3:0] bc_m, bc_a, bc_n;
   logic       t16_m, t16_a, t16_n, c4_m, c4_a, c4_n, bl_m, bl_a, bl_n;
   always #5 clk = ~clk;
   cga_attrib_ctrl u_main (
      .clk(clk), .reset(reset), .io_cs(io_cs), .io_a(io_a), .io_wr(io_wr), .io_rd(io_rd),
      .io_din(io_din), .io_dout(dout_m), .vsync(vsync), .display_enable(display_enable),
      .hres_mode(mode_m[0]), .grph_mode(mode_m[1]), .bw_mode(mode_m[2]), .video_enable(mode_m[3]),
      .mode_640(mode_m[4]), .blink_enabled(mode_m[5]), .cga_color_reg(col_m),
      .tandy_bordercol(bc_m), .tandy_16_mode(t16_m), .tandy_color_4(c4_m), .blink(bl_m));
   cga_attrib_ctrl #(.SYNC_UPDATE(1'b0)) u_async (
      .clk(clk), .reset(reset), .io_cs(io_cs), .io_a(io_a), .io_wr(io_wr), .io_rd(io_rd),
      .io_din(io_din), .io_dout(dout_a), .vsync(vsync), .display_enable(display_enable),
      .hres_mode(mode_a[0]), .grph_mode(mode_a[1]), .bw_mode(mode_a[2]), .video_enable(mode_a[3]),
      .mode_640(mode_a[4]), .blink_enabled(mode_a[5]), .cga_color_reg(col_a),
      .tandy_bordercol(bc_a), .tandy_16_mode(t16_a), .tandy_color_4(c4_a), .blink(bl_a));
   cga_attrib_ctrl #(.TANDY_EN(1'b0)) u_notandy (
      .clk(clk), .reset(reset), .io_cs(io_cs), .io_a(io_a), .io_wr(io_wr), .io_rd(io_rd),
      .io_din(io_din), .io_dout(dout_n), .vsync(vsync), .display_enable(display_enable),
      .hres_mode(mode_n[0]), .grph_mode(mode_n[1]), .bw_mode(mode_n[2]), .video_enable(mode_n[3]),
      .mode_640(mode_n[4]), .blink_enabled(mode_n[5]), .cga_color_reg(col_n),
      .tandy_bordercol(bc_n), .tandy_16_mode(t16_n), .tandy_color_4(c4_n), .blink(bl_n));
   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic do_reset();
      reset = 1;
      step();
      reset = 0;
   endtask
   task automatic io_write(input logic [3:0] a, input logic [7:0] d);
      io_cs = 1; io_wr = 1; io_a = a; io_din = d;
      step();
      io_cs = 0; io_wr = 0;
   endtask
   task automatic io_read(input logic [3:0] a);
      io_cs = 1; io_rd = 1; io_a = a;
      step();
      io_cs = 0; io_rd = 0;
   endtask
   task automatic vs_pulse();
      vsync = 1;
      step(2);
      vsync = 0;
      step(2);
   endtask
   task automatic test_reset();
      do_reset();
      checks++; if (mode_m !== 6'h00) begin failures++; $display("FAIL reset_mode got=%h exp=00", mode_m); end
      checks++; if (col_m !== 8'h00) begin failures++; $display("FAIL reset_color got=%h exp=00", col_m); end
      checks++; if (dout_m !== 8'hFF) begin failures++; $display("FAIL reset_dout got=%h exp=FF", dout_m); end
      checks++; if ({bc_m, t16_m, c4_m, bl_m} !== 7'h00) begin failures++; $display("FAIL reset_tandy_blink got=%h exp=00", {bc_m, t16_m, c4_m, bl_m}); end
   endtask
   task automatic test_mode_staged();
      io_write(4'h8, 8'h29);
      step(3);
      checks++; if (mode_m !== 6'h00) begin failures++; $display("FAIL staged_hold got=%h exp=00", mode_m); end
      io_read(4'h8);
      checks++; if (dout_m !== 8'hE9) begin failures++; $display("FAIL read_mode got=%h exp=E9", dout_m); end
      vsync = 1;
      step(2);
      checks++; if (mode_m !== 6'h29) begin failures++; $display("FAIL staged_apply got=%h exp=29", mode_m); end
      checks++; if ({mode_m[0], mode_m[3], mode_m[5]} !== 3'b111) begin failures++; $display("FAIL staged_bits got=%b exp=111", {mode_m[0], mode_m[3], mode_m[5]}); end
      vsync = 0;
      step(2);
   endtask
   task automatic test_async();
      io_write(4'h9, 8'h3F);
      step();
      checks++; if (col_a !== 8'h3F) begin failures++; $display("FAIL async_color got=%h exp=3F", col_a); end
      checks++; if (col_m !== 8'h00) begin failures++; $display("FAIL sync_color_hold got=%h exp=00", col_m); end
      io_read(4'h9);
      checks++; if (dout_m !== 8'h3F) begin failures++; $display("FAIL read_color got=%h exp=3F", dout_m); end
   endtask
   task automatic test_tandy();
      io_write(4'hA, 8'h02);
      io_write(4'hE, 8'h0C);
      io_write(4'hA, 8'h03);
      io_write(4'hE, 8'h18);
      step();
      checks++; if ({bc_m, t16_m, c4_m} !== 6'h00) begin failures++; $display("FAIL tandy_hold got=%h exp=00", {bc_m, t16_m, c4_m}); end
      vs_pulse();
      checks++; if ({bc_m, t16_m, c4_m} !== 6'h33) begin failures++; $display("FAIL tandy_apply got=%h exp=33", {bc_m, t16_m, c4_m}); end
      checks++; if ({bc_n, t16_n, c4_n} !== 6'h00) begin failures++; $display("FAIL tandy_disabled got=%h exp=00", {bc_n, t16_n, c4_n}); end
      checks++; if (col_m !== 8'h3F) begin failures++; $display("FAIL color_after_vsync got=%h exp=3F", col_m); end
   endtask
   task automatic test_status_read();
      vsync = 1; display_enable = 0;
      io_read(4'hA);
      checks++; if (dout_m !== 8'hFD) begin failures++; $display("FAIL status_vs1_de0 got=%h exp=FD", dout_m); end
      vsync = 0; display_enable = 1;
      step(2);
      checks++; if (dout_m !== 8'hFD) begin failures++; $display("FAIL dout_hold got=%h exp=FD", dout_m); end
      io_read(4'hA);
      checks++; if (dout_m !== 8'hF4) begin failures++; $display("FAIL status_vs0_de1 got=%h exp=F4", dout_m); end
      io_read(4'h3);
      checks++; if (dout_m !== 8'hFF) begin failures++; $display("FAIL read_unused got=%h exp=FF", dout_m); end
      io_cs = 1; io_rd = 1; io_wr = 1; io_a = 4'h9; io_din = 8'h55;
      step();
      io_cs = 0; io_rd = 0; io_wr = 0;
      checks++; if (dout_m !== 8'hFF) begin failures++; $display("FAIL rdwr_dout got=%h exp=FF", dout_m); end
      io_read(4'h9);
      checks++; if (dout_m !== 8'h55) begin failures++; $display("FAIL rdwr_write got=%h exp=55", dout_m); end
      io_write(4'h2, 8'h00);
      io_read(4'h9);
      checks++; if (dout_m !== 8'h55) begin failures++; $display("FAIL unused_write got=%h exp=55", dout_m); end
   endtask
   task automatic test_back_to_back();
      vsync = 1;
      step();
      io_write(4'h8, 8'h12);
      checks++; if (mode_m !== 6'h12) begin failures++; $display("FAIL write_at_load got=%h exp=12", mode_m); end
      vsync = 0;
      step(2);
      io_write(4'h8, 8'h3F);
      io_write(4'h9, 8'hA5);
      do_reset();
      checks++; if ({mode_m, col_m} !== 14'h0) begin failures++; $display("FAIL reset_after got=%h exp=0", {mode_m, col_m}); end
      vs_pulse();
      checks++; if ({mode_m, col_m} !== 14'h0) begin failures++; $display("FAIL stage_discard got=%h exp=0", {mode_m, col_m}); end
   endtask
   task automatic test_blink();
      do_reset();
      for (int k = 1; k <= 32; k++) begin
         vs_pulse();
         checks++; if (bl_m !== 1'((k / 8) % 2)) begin failures++; $display("FAIL blink_%0d got=%b exp=%b", k, bl_m, 1'((k / 8) % 2)); end
      end
   endtask
   initial begin
      step(2);
      test_reset();
      test_mode_staged();
      test_async();
      test_tandy();
      test_status_read();
      test_back_to_back();
      test_blink();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
